// File: rtl/reg_ring_master_if.sv
// Command/response handshake and register-ring request/return signals for reg_ring_master.
// The master modport is the ring master's view; slave is the driver/responder side.
interface reg_ring_master_if #(
    parameter int UDP_REG_SRC_WIDTH = 2
);
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic                         cmd_rd_wr_L;
    logic [22:0]                  cmd_addr;
    logic [31:0]                  cmd_wdata;

    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [31:0]                  rsp_data;
    logic                         rsp_err;
    logic                         rsp_timeout;

    logic                         reg_req_out;
    logic                         reg_ack_out;
    logic                         reg_rd_wr_L_out;
    logic [22:0]                  reg_addr_out;
    logic [31:0]                  reg_data_out;
    logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out;

    logic                         reg_req_in;
    logic                         reg_ack_in;
    logic                         reg_rd_wr_L_in;
    logic [22:0]                  reg_addr_in;
    logic [31:0]                  reg_data_in;
    logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in;

    modport master (
        input  cmd_valid, cmd_rd_wr_L, cmd_addr, cmd_wdata, rsp_ready,
        input  reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout,
        output reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out
    );

    modport slave (
        output cmd_valid, cmd_rd_wr_L, cmd_addr, cmd_wdata, rsp_ready,
        output reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout,
        input  reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out
    );
endinterface

// File: rtl/reg_ring_master.sv
// Register-ring master: issues one command at a time onto the ring, waits for its own
// return (or times out), presents a response, and flushes the ring after a timeout.
module reg_ring_master #(
    parameter int UDP_REG_SRC_WIDTH = 2,
    parameter int SRC_ID            = 0,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic              clk,
    input  logic              reset,
    reg_ring_master_if.master bus
);
    localparam int CNT_W      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int FLUSH_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [CNT_W-1:0]             CNT_TIMEOUT    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]             CNT_FLUSH_LAST = CNT_W'(FLUSH_LAST);
    localparam logic [UDP_REG_SRC_WIDTH-1:0] OWN_SRC        = UDP_REG_SRC_WIDTH'(SRC_ID);
    localparam logic [31:0]                  TIMEOUT_DATA   = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        FLUSH
    } state_t;

    state_t                       r_state;
    logic [CNT_W-1:0]             r_cnt;
    logic [22:0]                  r_addr;
    logic                         r_cmdReady;
    logic                         r_rspValid;
    logic [31:0]                  r_rspData;
    logic                         r_rspErr;
    logic                         r_rspTimeout;
    logic                         r_reqOut;
    logic                         r_rdWrOut;
    logic [22:0]                  r_addrOut;
    logic [31:0]                  r_dataOut;
    logic [UDP_REG_SRC_WIDTH-1:0] r_srcOut;
    logic                         w_match;

    // Only a return stamped with our source ID and the outstanding address is ours.
    assign w_match = bus.reg_req_in
                   && (bus.reg_src_in == OWN_SRC)
                   && (bus.reg_addr_in == r_addr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_cmdReady   <= 1'b0;
            r_rspValid   <= 1'b0;
            r_rspData    <= '0;
            r_rspErr     <= 1'b0;
            r_rspTimeout <= 1'b0;
            r_reqOut     <= 1'b0;
            r_rdWrOut    <= 1'b0;
            r_addrOut    <= '0;
            r_dataOut    <= '0;
            r_srcOut     <= '0;
        end else begin
            r_reqOut  <= 1'b0;
            r_rdWrOut <= 1'b0;
            r_addrOut <= '0;
            r_dataOut <= '0;
            r_srcOut  <= '0;
            case (r_state)
                IDLE: begin
                    if (r_cmdReady && bus.cmd_valid) begin
                        r_cmdReady <= 1'b0;
                        r_addr     <= bus.cmd_addr;
                        r_reqOut   <= 1'b1;
                        r_rdWrOut  <= bus.cmd_rd_wr_L;
                        r_addrOut  <= bus.cmd_addr;
                        r_dataOut  <= bus.cmd_wdata;
                        r_srcOut   <= OWN_SRC;
                        r_state    <= ISSUE;
                    end else begin
                        r_cmdReady <= 1'b1;
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // A matching return on the final counted cycle still beats the timeout.
                    if (w_match) begin
                        r_rspData    <= bus.reg_data_in;
                        r_rspErr     <= ~bus.reg_ack_in;
                        r_rspTimeout <= 1'b0;
                        r_rspValid   <= 1'b1;
                        r_state      <= RESP;
                    end else if (r_cnt == CNT_TIMEOUT) begin
                        r_rspData    <= TIMEOUT_DATA;
                        r_rspErr     <= 1'b1;
                        r_rspTimeout <= 1'b1;
                        r_rspValid   <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_cnt      <= '0;
                        if (r_rspTimeout) begin
                            r_state <= FLUSH;
                        end else begin
                            r_cmdReady <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    // Drain long enough that a straggling ack cannot pair with the next command.
                    if (r_cnt == CNT_FLUSH_LAST) begin
                        r_cmdReady <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cmdReady <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready       = r_cmdReady;
    assign bus.rsp_valid       = r_rspValid;
    assign bus.rsp_data        = r_rspData;
    assign bus.rsp_err         = r_rspErr;
    assign bus.rsp_timeout     = r_rspTimeout;
    assign bus.reg_req_out     = r_reqOut;
    assign bus.reg_ack_out     = 1'b0;
    assign bus.reg_rd_wr_L_out = r_rdWrOut;
    assign bus.reg_addr_out    = r_addrOut;
    assign bus.reg_data_out    = r_dataOut;
    assign bus.reg_src_out     = r_srcOut;
endmodule

// File: tb/tb_reg_ring_master.sv
// Self-checking bench for reg_ring_master: directed scenarios plus randomized transactions
// checked against a response model derived from the return/timeout rules.
module tb_reg_ring_master;
    localparam int         T   = 8;
    localparam logic [1:0] SRC = 2'd2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cycleCnt    = 0;

    typedef struct {
        logic [88:0] issue;
        int          pulses;
        int          latency;
        logic [31:0] data;
        logic        err;
        logic        to;
        logic        changed;
        logic        readyAfter;
        int          acceptCycle;
    } obs_t;

    reg_ring_master_if #(.UDP_REG_SRC_WIDTH(2)) bus ();

    reg_ring_master #(
        .UDP_REG_SRC_WIDTH(2),
        .SRC_ID           (2),
        .TIMEOUT_CYCLES   (T)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 500us");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ringIdle();
        bus.reg_req_in     = 1'b0;
        bus.reg_ack_in     = 1'b0;
        bus.reg_rd_wr_L_in = 1'b0;
        bus.reg_addr_in    = '0;
        bus.reg_data_in    = '0;
        bus.reg_src_in     = '0;
    endtask

    task automatic ringDrive(input logic ack, input logic [1:0] src,
                             input logic [22:0] addr, input logic [31:0] data);
        bus.reg_req_in     = 1'b1;
        bus.reg_ack_in     = ack;
        bus.reg_rd_wr_L_in = 1'b0;
        bus.reg_addr_in    = addr;
        bus.reg_data_in    = data;
        bus.reg_src_in     = src;
    endtask

    // Response the master owes for a return arriving after matchAt empty WAIT cycles (-1 = never).
    function automatic void refModel(input int matchAt, input bit ack, input logic [31:0] retData,
                                     output logic [31:0] d, output logic e, output logic t,
                                     output int lat);
        if (matchAt >= 0 && matchAt <= T) begin
            d = retData; e = ~ack; t = 1'b0; lat = matchAt;
        end else begin
            d = 32'hDEAD_BEEF; e = 1'b1; t = 1'b1; lat = T;
        end
    endfunction

    task automatic runTxn(input bit rd, input logic [22:0] addr, input logic [31:0] wdata,
                          input int matchAt, input bit ack, input logic [31:0] retData,
                          input int foreignAt, input bit foreignKind, input int hold,
                          output obs_t o);
        int guard;
        o = '{issue: '0, pulses: 0, latency: -1, data: '0, err: 1'b0, to: 1'b0,
              changed: 1'b0, readyAfter: 1'b0, acceptCycle: 0};
        guard = 0;
        while (bus.cmd_ready !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        bus.cmd_valid   = 1'b1;
        bus.cmd_rd_wr_L = rd;
        bus.cmd_addr    = addr;
        bus.cmd_wdata   = wdata;
        step();
        bus.cmd_valid   = 1'b0;
        bus.cmd_addr    = 23'($urandom);
        bus.cmd_wdata   = $urandom;
        o.acceptCycle   = cycleCnt;
        o.issue = {bus.reg_req_out, bus.reg_ack_out, bus.reg_rd_wr_L_out, bus.reg_src_out,
                   bus.reg_addr_out, bus.reg_data_out};
        if (bus.reg_req_out === 1'b1) o.pulses++;
        ringIdle();
        step();
        if (bus.reg_req_out === 1'b1) o.pulses++;
        for (int k = 0; k < T + 6; k++) begin
            if (k == matchAt)        ringDrive(ack, SRC, addr, retData);
            else if (k == foreignAt) ringDrive(1'b1, foreignKind ? SRC : (SRC ^ 2'd1),
                                               foreignKind ? (addr ^ 23'h1) : addr, $urandom);
            else                     ringIdle();
            step();
            if (bus.reg_req_out === 1'b1) o.pulses++;
            if (bus.rsp_valid === 1'b1) begin
                o.latency = k;
                break;
            end
        end
        ringIdle();
        if (o.latency >= 0) begin
            o.data = bus.rsp_data;
            o.err  = bus.rsp_err;
            o.to   = bus.rsp_timeout;
            for (int h = 0; h < hold; h++) begin
                step();
                if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== o.data ||
                    bus.rsp_err !== o.err || bus.rsp_timeout !== o.to) o.changed = 1'b1;
            end
            bus.rsp_ready = 1'b1;
            step();
            bus.rsp_ready = 1'b0;
            o.readyAfter = bus.cmd_ready;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_rd_wr_L = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        ringIdle();
        step(); step();
        vectors++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_data,
             bus.reg_req_out, bus.reg_ack_out, bus.reg_rd_wr_L_out, bus.reg_addr_out,
             bus.reg_data_out, bus.reg_src_out} !== 96'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got nonzero outputs (cmd_ready=%b rsp_valid=%b rsp_data=%h), expected all 0",
                     bus.cmd_ready, bus.rsp_valid, bus.rsp_data);
        end
        reset = 1'b1;
        vectors++;
        if (bus.cmd_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ready_before_edge: got %b expected 0", bus.cmd_ready);
        end
        step();
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ready_after_reset: got %b expected 1", bus.cmd_ready);
        end
    endtask

    task automatic test_read_ack();
        obs_t o;
        runTxn(1'b1, 23'h400004, 32'h0, 3, 1'b1, 32'h1234_5678, -1, 1'b0, 0, o);
        vectors++;
        if (o.issue !== {1'b1, 1'b0, 1'b1, SRC, 23'h400004, 32'h0}) begin
            miscompares++;
            $display("[TB] FAIL read_issue: got %h expected %h", o.issue,
                     {1'b1, 1'b0, 1'b1, SRC, 23'h400004, 32'h0});
        end
        vectors++;
        if ({o.data, o.err, o.to} !== {32'h1234_5678, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL read_rsp: got data=%h err=%b to=%b expected 12345678/0/0", o.data, o.err, o.to);
        end
        vectors++;
        if (o.latency !== 3 || o.pulses !== 1) begin
            miscompares++;
            $display("[TB] FAIL read_timing: got latency=%0d pulses=%0d expected 3/1", o.latency, o.pulses);
        end
    endtask

    task automatic test_write_noack();
        obs_t o;
        runTxn(1'b0, 23'h000010, 32'hA5A5_A5A5, 1, 1'b0, 32'hA5A5_A5A5, -1, 1'b0, 0, o);
        vectors++;
        if (o.issue !== {1'b1, 1'b0, 1'b0, SRC, 23'h000010, 32'hA5A5_A5A5}) begin
            miscompares++;
            $display("[TB] FAIL write_issue: got %h", o.issue);
        end
        vectors++;
        if ({o.data, o.err, o.to} !== {32'hA5A5_A5A5, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL write_noack: got data=%h err=%b to=%b expected a5a5a5a5/1/0", o.data, o.err, o.to);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        int   n;
        logic sawRsp;
        runTxn(1'b1, 23'h0ABCDE, 32'h0, -1, 1'b1, 32'h0, -1, 1'b0, 0, o);
        vectors++;
        if ({o.data, o.err, o.to} !== {32'hDEAD_BEEF, 1'b1, 1'b1} || o.latency !== T) begin
            miscompares++;
            $display("[TB] FAIL timeout_rsp: got data=%h err=%b to=%b lat=%0d expected deadbeef/1/1/%0d",
                     o.data, o.err, o.to, o.latency, T);
        end
        n = 0;
        sawRsp = 1'b0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            if (n == 3) ringDrive(1'b1, SRC, 23'h0ABCDE, 32'h0BAD_0BAD);
            else        ringIdle();
            step();
            n++;
            if (bus.rsp_valid === 1'b1) sawRsp = 1'b1;
        end
        ringIdle();
        step(); step();
        if (bus.rsp_valid === 1'b1) sawRsp = 1'b1;
        vectors++;
        if (n !== T) begin
            miscompares++;
            $display("[TB] FAIL flush_length: got %0d cycles of cmd_ready=0 expected %0d", n, T);
        end
        vectors++;
        if (sawRsp !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_late_return: got response %b expected 0", sawRsp);
        end
    endtask

    task automatic test_foreign();
        obs_t o;
        for (int kind = 0; kind < 2; kind++) begin
            runTxn(1'b1, 23'h001234, 32'h0, 4, 1'b1, 32'hC0DE_0000 + kind, 1, kind[0], 0, o);
            vectors++;
            if ({o.data, o.err, o.to} !== {32'hC0DE_0000 + kind, 1'b0, 1'b0} || o.latency !== 4) begin
                miscompares++;
                $display("[TB] FAIL foreign_kind%0d: got data=%h err=%b to=%b lat=%0d expected %h/0/0/4",
                         kind, o.data, o.err, o.to, o.latency, 32'hC0DE_0000 + kind);
            end
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        runTxn(1'b1, 23'h7FFFFF, 32'h0, 2, 1'b1, 32'h5A5A_1111, -1, 1'b0, 5, o);
        vectors++;
        if (o.changed !== 1'b0 || o.data !== 32'h5A5A_1111) begin
            miscompares++;
            $display("[TB] FAIL backpressure_hold: got changed=%b data=%h expected 0/5a5a1111", o.changed, o.data);
        end
        runTxn(1'b1, 23'h00FACE, 32'h0, T, 1'b1, 32'h7777_0008, -1, 1'b0, 0, o);
        vectors++;
        if ({o.data, o.err, o.to} !== {32'h7777_0008, 1'b0, 1'b0} || o.latency !== T) begin
            miscompares++;
            $display("[TB] FAIL boundary_return_wins: got data=%h err=%b to=%b lat=%0d expected 77770008/0/0/%0d",
                     o.data, o.err, o.to, o.latency, T);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1;
        obs_t o2;
        runTxn(1'b0, 23'h000100, 32'h1111_2222, 0, 1'b1, 32'h1111_2222, -1, 1'b0, 0, o1);
        runTxn(1'b0, 23'h000104, 32'h3333_4444, 0, 1'b1, 32'h3333_4444, -1, 1'b0, 0, o2);
        vectors++;
        if (o1.readyAfter !== 1'b1 || (o2.acceptCycle - o1.acceptCycle) !== 4) begin
            miscompares++;
            $display("[TB] FAIL back_to_back: got readyAfter=%b spacing=%0d expected 1/4",
                     o1.readyAfter, o2.acceptCycle - o1.acceptCycle);
        end
        vectors++;
        if (o2.data !== 32'h3333_4444 || o2.err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL back_to_back_data: got %h/%b expected 33334444/0", o2.data, o2.err);
        end
    endtask

    task automatic test_random();
        obs_t        o;
        bit          rd;
        bit          ack;
        bit          kind;
        logic [22:0] addr;
        logic [31:0] wdata;
        logic [31:0] ret;
        logic [31:0] expD;
        logic        expE;
        logic        expT;
        int          expL;
        int          matchAt;
        int          foreignAt;
        for (int i = 0; i < 16; i++) begin
            rd        = 1'($urandom_range(0, 1));
            ack       = 1'($urandom_range(0, 1));
            kind      = 1'($urandom_range(0, 1));
            addr      = 23'($urandom);
            wdata     = $urandom;
            ret       = rd ? $urandom : wdata;
            matchAt   = int'($urandom_range(0, T + 2)) - 1;
            foreignAt = int'($urandom_range(0, T));
            runTxn(rd, addr, wdata, matchAt, ack, ret, foreignAt, kind,
                   int'($urandom_range(0, 3)), o);
            refModel(matchAt, ack, ret, expD, expE, expT, expL);
            vectors++;
            if (o.issue !== {1'b1, 1'b0, rd, SRC, addr, wdata} || o.pulses !== 1) begin
                miscompares++;
                $display("[TB] FAIL rand%0d_issue: got %h pulses=%0d expected %h pulses=1",
                         i, o.issue, o.pulses, {1'b1, 1'b0, rd, SRC, addr, wdata});
            end
            vectors++;
            if ({o.data, o.err, o.to} !== {expD, expE, expT} || o.latency !== expL || o.changed !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL rand%0d_rsp: got %h/%b/%b lat=%0d chg=%b expected %h/%b/%b lat=%0d",
                         i, o.data, o.err, o.to, o.latency, o.changed, expD, expE, expT, expL);
            end
        end
    endtask

    task automatic test_mid_reset();
        obs_t o;
        int   guard;
        guard = 0;
        while (bus.cmd_ready !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        bus.cmd_valid = 1'b1; bus.cmd_rd_wr_L = 1'b1; bus.cmd_addr = 23'h123456; bus.cmd_wdata = 32'h0;
        step();
        bus.cmd_valid = 1'b0;
        step(); step();
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_data,
             bus.reg_req_out, bus.reg_ack_out, bus.reg_rd_wr_L_out, bus.reg_addr_out,
             bus.reg_data_out, bus.reg_src_out} !== 96'h0) begin
            miscompares++;
            $display("[TB] FAIL midreset_outputs: got nonzero (cmd_ready=%b rsp_data=%h) expected all 0",
                     bus.cmd_ready, bus.rsp_data);
        end
        ringDrive(1'b1, SRC, 23'h123456, 32'hFEED_FACE);
        step();
        reset = 1'b1;
        step();
        vectors++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_release: got ready=%b valid=%b expected 1/0", bus.cmd_ready, bus.rsp_valid);
        end
        ringIdle();
        runTxn(1'b1, 23'h123456, 32'h0, 2, 1'b1, 32'h600D_D47A, -1, 1'b0, 0, o);
        vectors++;
        if ({o.data, o.err, o.to} !== {32'h600D_D47A, 1'b0, 1'b0} || o.latency !== 2) begin
            miscompares++;
            $display("[TB] FAIL midreset_next_read: got %h/%b/%b lat=%0d expected 600dd47a/0/0/2",
                     o.data, o.err, o.to, o.latency);
        end
    endtask

    initial begin
        test_reset();
        test_read_ack();
        test_write_noack();
        test_timeout();
        test_foreign();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reg_ring_master.md
REG_RING_MASTER -- requirements
Module: reg_ring_master

Interface
REQ-001 Parameter UDP_REG_SRC_WIDTH, default 2, width of the source-ID field.
REQ-002 Parameter SRC_ID, default 0, source ID stamped on issued requests.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, cycles to wait for a returned transaction.
REQ-004 clk  input  1  sole clock; all logic is rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid / cmd_ready  input / output  1 / 1  command handshake.
REQ-007 cmd_rd_wr_L  input  1  1 = read, 0 = write.
REQ-008 cmd_addr  input  23  register address.
REQ-009 cmd_wdata  input  32  write data.
REQ-010 rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-011 rsp_data  output  32  read data, or echoed write data.
REQ-012 rsp_err  output  1  1 = no responder acked, or timeout.
REQ-013 rsp_timeout  output  1  1 = timeout occurred.
REQ-014 reg_req_out, reg_ack_out, reg_rd_wr_L_out  output  1 each  ring request outputs.
REQ-015 reg_addr_out  output  23  ring request address.
REQ-016 reg_data_out  output  32  ring request data.
REQ-017 reg_src_out  output  UDP_REG_SRC_WIDTH  ring request source ID.
REQ-018 reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in  input  same widths as the matching outputs  ring return from the last responder.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP and FLUSH, with one transaction outstanding at most.
REQ-020 cmd_ready SHALL be 1 only in IDLE.
- On cmd_valid&cmd_ready, the command is latched into internal registers.
- Next state is ISSUE.
REQ-021 In ISSUE, for exactly one cycle, the block SHALL drive:
- reg_req_out=1, reg_ack_out=0;
- latched rd_wr_L, addr and data;
- reg_src_out=SRC_ID.
- Next state is WAIT.
REQ-022 Outside ISSUE, all reg_*_out SHALL be 0.
REQ-023 In WAIT, a return is a cycle with reg_req_in=1 and reg_src_in==SRC_ID and reg_addr_in==latched addr; a return SHALL:
- capture rsp_data = reg_data_in;
- capture rsp_err = ~reg_ack_in;
- set rsp_timeout = 0;
- move to RESP.
REQ-024 Ring inputs with reg_req_in=1 that do not match REQ-023 SHALL be discarded in every state, with no output effect.
REQ-025 The WAIT counter SHALL:
- clear on entry to WAIT;
- increment each WAIT cycle without a return.
REQ-026 When the WAIT counter reaches TIMEOUT_CYCLES, the block SHALL set rsp_err=1, rsp_timeout=1 and rsp_data=32'hDEAD_BEEF, then move to RESP.
REQ-027 A return arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win; no timeout is flagged.
REQ-028 rsp_valid SHALL be 1 exactly in RESP, and rsp_data, rsp_err and rsp_timeout SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-029 On rsp_valid&rsp_ready, the next state SHALL be:
- FLUSH if rsp_timeout=1;
- IDLE otherwise.
REQ-030 FLUSH SHALL last TIMEOUT_CYCLES cycles, discarding all returns so that a late ack is never matched to a later command, then go to IDLE.
REQ-031 Minimum latency SHALL be:
- cmd accept to reg_req_out: 1 cycle;
- return to rsp_valid: 1 cycle.
- Back-to-back commands: IDLE must be re-entered, giving a minimum of 4 cycles per transaction.
REQ-032 cmd_valid asserted outside IDLE SHALL be ignored (cmd_ready=0); the command is not lost from the source side.

Reset
REQ-033 While reset=0, the block SHALL:
- force the state to IDLE;
- clear the WAIT counter and all latched fields;
- drive all reg_*_out, rsp_valid, rsp_err, rsp_timeout and rsp_data to 0;
- drive cmd_ready to 0.
REQ-034 After reset deasserts, cmd_ready SHALL be 1 on the first rising edge.
REQ-035 Reset asserted mid-transaction SHALL abandon the transaction immediately, with no response produced.
REQ-036 After that reset, the block SHALL return to IDLE, discarding any later return.

Verification
REQ-037 Read with ack: cmd read addr 0x400004; responder returns req=1, ack=1, data 0x12345678 after 3 cycles -> rsp_valid with rsp_data=0x12345678, rsp_err=0, rsp_timeout=0; exactly one reg_req_out pulse observed.
REQ-038 Unacked write: cmd write addr 0x000010, data 0xA5A5A5A5; return with ack=0 -> rsp_err=1, rsp_timeout=0, rsp_data=0xA5A5A5A5.
REQ-039 Timeout: TIMEOUT_CYCLES=8, no return -> rsp_valid, rsp_err=1, rsp_timeout=1, rsp_data=0xDEADBEEF; cmd_ready stays 0 for 8 FLUSH cycles after the handshake; a late matching return during FLUSH produces no response.
REQ-040 Foreign traffic: return with reg_src_in≠SRC_ID, or a mismatched address, during WAIT -> ignored; the later matching return completes normally.
REQ-041 Backpressure and boundary: hold rsp_ready=0 for 5 cycles -> outputs stable; then a return arriving on the timeout cycle -> rsp_timeout=0.
REQ-042 Mid-operation reset: reset=0 during WAIT -> all outputs 0 immediately; after release, cmd_ready=1 and the next read completes normally.
